// File: rtl/beeb_host_bus_if.sv
// beeb_host_bus_if: 6502 socket bus between the accelerator's CPU-side master
// and the host-side responder (beeb_host_bus).
//   phi0        2 MHz phase clock (low = Phi1, high = Phi2), responder -> CPU
//   addr        16-bit CPU address, CPU -> responder
//   r_w_n       1 = read, 0 = write, CPU -> responder
//   data_i      CPU write data, CPU -> responder
//   data_o      read data, responder -> CPU
//   data_oe     drive enable for data_o
//   irq_n       active-low interrupt to the CPU
//   stretch     high during a stretched Phi2
//   cycle_count completed bus cycles, wraps at 2^16
interface beeb_host_bus_if;
   logic        phi0;
   logic [15:0] addr;
   logic        r_w_n;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        data_oe;
   logic        irq_n;
   logic        stretch;
   logic [15:0] cycle_count;

   modport master (
      input  phi0, data_o, data_oe, irq_n, stretch, cycle_count,
      output addr, r_w_n, data_i
   );

   modport slave (
      output phi0, data_o, data_oe, irq_n, stretch, cycle_count,
      input  addr, r_w_n, data_i
   );
endinterface

// File: rtl/beeb_host_bus.sv
// beeb_host_bus: host-side responder standing in for the Beeb motherboard.
// Generates phi0, latches address/direction at the end of Phi1, serves reads
// from a mirrored RAM and a small register window, and commits writes on the
// falling edge of phi0.
//   cpu_clk  sole clock
//   reset    synchronous, active-high
//   bus      beeb_host_bus_if.slave (phi0, addr, r_w_n, data_i, data_o,
//            data_oe, irq_n, stretch, cycle_count)
// Registers: 0xFE40 irq_pend (R/W bit0), 0xFE41 cycle_count[7:0] (R, snapshots
// the high byte), 0xFE42 snapshot high byte (R).
// Optional feature macro BEEB_HOST_STRETCH_EN: stretches Phi2 for accesses to
// 0xFC00..0xFEFF (3 or 5 half ticks depending on the 1 MHz phase).
module beeb_host_bus #(
   parameter int unsigned HALF_DIV = 25,
   parameter int unsigned MEM_AW   = 12
) (
   input logic           cpu_clk,
   input logic           reset,
   beeb_host_bus_if.slave bus
);

   typedef enum logic [0:0] {StPh1, StPh2} state_e;

   localparam logic [15:0] AddrIrq   = 16'hFE40;
   localparam logic [15:0] AddrCntLo = 16'hFE41;
   localparam logic [15:0] AddrCntHi = 16'hFE42;

   state_e      state_q;
   logic [7:0]  hc_q;
   logic [15:0] addr_q;
   logic        rw_q;
   logic [2:0]  ph2_left_q;   // half ticks of Phi2 still to run after this one
   logic        first_q;      // first cpu_clk of Phi2: lookup stage
   logic        pipe_q;       // second cpu_clk of Phi2: drive stage
   logic        phi0_q;
   logic [7:0]  data_o_q;
   logic        data_oe_q;
   logic        irq_n_q;
   logic [15:0] cnt_q;
   logic [7:0]  shadow_q;
   logic        reg_sel_q;
   logic [7:0]  reg_val_q;
   logic [7:0]  ram_rd_q;
   logic [7:0]  ram_q [2**MEM_AW];

   logic tick;
   logic slow;
   logic is_reg;
   logic ph2_end;
   logic ram_we;

   assign tick    = (hc_q == 8'(HALF_DIV - 1));
   assign is_reg  = (addr_q == AddrIrq) || (addr_q == AddrCntLo) || (addr_q == AddrCntHi);
   assign ph2_end = (state_q == StPh2) && tick && (ph2_left_q == 3'd0);
   // A reset on the commit edge aborts the cycle, so it must also block the write.
   assign ram_we  = !reset && ph2_end && !rw_q && !is_reg;

`ifdef BEEB_HOST_STRETCH_EN
   logic onemhz_q;
   logic par_q;
   logic stretch_q;
   assign slow        = (bus.addr >= 16'hFC00) && (bus.addr <= 16'hFEFF);
   assign bus.stretch = stretch_q;
`else
   assign slow        = 1'b0;
   assign bus.stretch = 1'b0;
`endif

   assign bus.phi0        = phi0_q;
   assign bus.data_o      = data_o_q;
   assign bus.data_oe     = data_oe_q;
   assign bus.irq_n       = irq_n_q;
   assign bus.cycle_count = cnt_q;

   // RAM has no reset so contents survive a mid-cycle reset.
   always_ff @(posedge cpu_clk) begin
      ram_rd_q <= ram_q[addr_q[MEM_AW-1:0]];
      if (ram_we) begin
         ram_q[addr_q[MEM_AW-1:0]] <= bus.data_i;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q    <= StPh1;
         hc_q       <= 8'd0;
         addr_q     <= 16'd0;
         rw_q       <= 1'b1;
         ph2_left_q <= 3'd0;
         first_q    <= 1'b0;
         pipe_q     <= 1'b0;
         phi0_q     <= 1'b0;
         data_o_q   <= 8'd0;
         data_oe_q  <= 1'b0;
         irq_n_q    <= 1'b1;
         cnt_q      <= 16'd0;
         shadow_q   <= 8'd0;
         reg_sel_q  <= 1'b0;
         reg_val_q  <= 8'd0;
`ifdef BEEB_HOST_STRETCH_EN
         onemhz_q   <= 1'b0;
         par_q      <= 1'b0;
         stretch_q  <= 1'b0;
`endif
      end else begin
         hc_q <= tick ? 8'd0 : hc_q + 8'd1;
`ifdef BEEB_HOST_STRETCH_EN
         // onemhz flips on every second half tick regardless of bus state.
         if (tick) begin
            par_q <= ~par_q;
            if (par_q) begin
               onemhz_q <= ~onemhz_q;
            end
         end
`endif
         first_q <= 1'b0;
         pipe_q  <= first_q;

         if (first_q) begin
            reg_sel_q <= is_reg;
            case (addr_q)
               AddrIrq:   reg_val_q <= {7'd0, ~irq_n_q};
               AddrCntLo: begin
                  reg_val_q <= cnt_q[7:0];
                  if (rw_q) begin
                     shadow_q <= cnt_q[15:8];
                  end
               end
               AddrCntHi: reg_val_q <= shadow_q;
               default:   reg_val_q <= 8'd0;
            endcase
         end

         if (pipe_q) begin
            data_o_q  <= reg_sel_q ? reg_val_q : ram_rd_q;
            data_oe_q <= rw_q;
         end

         case (state_q)
            StPh1: begin
               if (tick) begin
                  state_q <= StPh2;
                  phi0_q  <= 1'b1;
                  addr_q  <= bus.addr;
                  rw_q    <= bus.r_w_n;
                  first_q <= 1'b1;
`ifdef BEEB_HOST_STRETCH_EN
                  stretch_q  <= slow;
                  ph2_left_q <= slow ? (onemhz_q ? 3'd4 : 3'd2) : 3'd0;
`else
                  ph2_left_q <= 3'd0;
`endif
               end
            end
            StPh2: begin
               if (tick) begin
                  if (ph2_left_q != 3'd0) begin
                     ph2_left_q <= ph2_left_q - 3'd1;
                  end else begin
                     state_q   <= StPh1;
                     phi0_q    <= 1'b0;
                     data_o_q  <= 8'd0;
                     data_oe_q <= 1'b0;
                     cnt_q     <= cnt_q + 16'd1;
`ifdef BEEB_HOST_STRETCH_EN
                     stretch_q <= 1'b0;
`endif
                     if (!rw_q && (addr_q == AddrIrq)) begin
                        irq_n_q <= ~bus.data_i[0];
                     end
                  end
               end
            end
            default: state_q <= StPh1;
         endcase
      end
   end

endmodule

// File: tb/tb_beeb_host_bus.sv
// Directed self-checking bench for beeb_host_bus. Outputs are sampled on the
// falling edge of cpu_clk; inputs are driven on the falling edge.
module tb_beeb_host_bus;

   localparam int unsigned HALF = 25;

   logic clk;
   logic rst;
   beeb_host_bus_if bus ();

   beeb_host_bus #(
      .HALF_DIV (HALF),
      .MEM_AW   (12)
   ) dut (
      .cpu_clk (clk),
      .reset   (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] m_count;     // expected cycle_count
   int unsigned m_ticks;     // half ticks elapsed since reset at start of the cycle
   int          last_hi;     // phi0-high length of the last cycle, in clocks
   logic        irq_pre;     // irq_n on the last cpu_clk before phi0 fell

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic abort(input string tag);
      n_err++;
      $display("FAIL %s: timeout waiting for phi0", tag);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "timeout");
   endtask

   function automatic logic is_slow(input logic [15:0] a);
`ifdef BEEB_HOST_STRETCH_EN
      return (a >= 16'hFC00) && (a <= 16'hFEFF);
`else
      return 1'b0;
`endif
   endfunction

   // Runs one bus cycle; must be entered on a falling edge with phi0 low.
   task automatic run_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                            input logic chk_rd, input logic [7:0] exp_rd, input string tag);
      int          lo;
      int          hi;
      logic        exp_slow;
      logic        om;
      int unsigned exp_len;
      logic        oe_last;
      logic [7:0]  do_last;
      chk({tag, ":count"}, bus.cycle_count, m_count);
      exp_slow = is_slow(a);
      om       = m_ticks[1];
      exp_len  = exp_slow ? (om ? 5 : 3) : 1;
      bus.addr   = a;
      bus.r_w_n  = rw;
      bus.data_i = wd;
      lo = 1;
      while (lo < 400) begin
         @(negedge clk);
         if (bus.phi0) break;
         lo++;
      end
      if (!bus.phi0) abort(tag);
      chk({tag, ":ph1_len"}, lo, HALF);
      chk({tag, ":stretch"}, bus.stretch, exp_slow);
      chk({tag, ":oe_early"}, bus.data_oe, 1'b0);
      // Latched at Phi1 exit; these changes must have no effect.
      bus.addr  = ~a;
      bus.r_w_n = ~rw;
      hi = 1;
      oe_last = bus.data_oe;
      do_last = bus.data_o;
      irq_pre = bus.irq_n;
      while (hi < 1000) begin
         @(negedge clk);
         if (!bus.phi0) break;
         hi++;
         if (hi == 3) begin
            chk({tag, ":oe"}, bus.data_oe, rw);
            if (rw && chk_rd) chk({tag, ":rdata"}, bus.data_o, exp_rd);
         end
         oe_last = bus.data_oe;
         do_last = bus.data_o;
         irq_pre = bus.irq_n;
      end
      if (bus.phi0) abort(tag);
      last_hi = hi;
      chk({tag, ":ph2_len"}, hi, exp_len * HALF);
      chk({tag, ":oe_hold"}, oe_last, rw);
      if (rw && chk_rd) chk({tag, ":rdata_hold"}, do_last, exp_rd);
      chk({tag, ":oe_off"}, bus.data_oe, 1'b0);
      m_count = m_count + 16'd1;
      m_ticks = m_ticks + 1 + exp_len;
   endtask

   initial begin
      int guard;
      rst        = 1'b1;
      bus.addr   = 16'h0000;
      bus.r_w_n  = 1'b1;
      bus.data_i = 8'h00;
      m_count    = 16'd0;
      m_ticks    = 0;
      repeat (3) @(negedge clk);
      chk("rst:phi0", bus.phi0, 1'b0);
      chk("rst:data_o", bus.data_o, 8'h00);
      chk("rst:data_oe", bus.data_oe, 1'b0);
      chk("rst:irq_n", bus.irq_n, 1'b1);
      chk("rst:stretch", bus.stretch, 1'b0);
      chk("rst:count", bus.cycle_count, 16'h0000);
      rst = 1'b0;

      // RAM write/read and mirroring
      run_cycle(16'h0123, 1'b0, 8'hA5, 1'b0, 8'h00, "wr0123");
      run_cycle(16'h0456, 1'b0, 8'h5A, 1'b0, 8'h00, "wr0456");
      run_cycle(16'h0123, 1'b1, 8'h00, 1'b1, 8'hA5, "rd0123");
      run_cycle(16'h1123, 1'b1, 8'h00, 1'b1, 8'hA5, "rd1123");
      run_cycle(16'hF456, 1'b1, 8'h00, 1'b1, 8'h5A, "rdF456");

      // IRQ register
      run_cycle(16'hFE40, 1'b0, 8'h01, 1'b0, 8'h00, "irq_set");
      chk("irq_set:pre", irq_pre, 1'b1);
      chk("irq_set:post", bus.irq_n, 1'b0);
      run_cycle(16'hFE40, 1'b1, 8'h00, 1'b1, 8'h01, "irq_rd1");
      run_cycle(16'hFE40, 1'b0, 8'h00, 1'b0, 8'h00, "irq_clr");
      chk("irq_clr:pre", irq_pre, 1'b0);
      chk("irq_clr:post", bus.irq_n, 1'b1);
      run_cycle(16'hFE40, 1'b1, 8'h00, 1'b1, 8'h00, "irq_rd0");

      // Slow-region stretching
      if (m_ticks[1]) run_cycle(16'h0010, 1'b1, 8'h00, 1'b0, 8'h00, "align");
      run_cycle(16'hFE60, 1'b1, 8'h00, 1'b0, 8'h00, "fe60_a");
`ifdef BEEB_HOST_STRETCH_EN
      chk("fe60_a:len75", last_hi, 75);
`else
      chk("fe60_a:len25", last_hi, 25);
`endif
      run_cycle(16'h0010, 1'b1, 8'h00, 1'b0, 8'h00, "flip");
      run_cycle(16'hFE60, 1'b1, 8'h00, 1'b0, 8'h00, "fe60_b");
`ifdef BEEB_HOST_STRETCH_EN
      chk("fe60_b:len125", last_hi, 125);
`else
      chk("fe60_b:len25", last_hi, 25);
`endif
      run_cycle(16'hFD00, 1'b1, 8'h00, 1'b0, 8'h00, "fd00");
      run_cycle(16'hFBFF, 1'b1, 8'h00, 1'b0, 8'h00, "fbff");
      chk("fbff:len25", last_hi, 25);

      // Counter snapshot
      guard = 0;
      while (m_count != 16'h01FF && guard < 1000) begin
         run_cycle(16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, "idle");
         guard++;
      end
      run_cycle(16'hFE41, 1'b1, 8'h00, 1'b1, 8'hFF, "cnt_lo");
      run_cycle(16'hFE42, 1'b1, 8'h00, 1'b1, 8'h01, "cnt_hi");
      run_cycle(16'hFE42, 1'b0, 8'h77, 1'b0, 8'h00, "wr_fe42");
      run_cycle(16'hFE42, 1'b1, 8'h00, 1'b1, 8'h01, "cnt_hi2");

      // Reset during a (slow, if enabled) write cycle
      run_cycle(16'hFD00, 1'b0, 8'h3C, 1'b0, 8'h00, "wrFD00");
      run_cycle(16'hFE40, 1'b0, 8'h01, 1'b0, 8'h00, "irq_set2");
      chk("irq_set2:post", bus.irq_n, 1'b0);
      bus.addr   = 16'hFD00;
      bus.r_w_n  = 1'b0;
      bus.data_i = 8'hC3;
      guard = 0;
      while (!bus.phi0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.phi0) abort("rst_mid");
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid:phi0", bus.phi0, 1'b0);
      chk("rst_mid:data_o", bus.data_o, 8'h00);
      chk("rst_mid:data_oe", bus.data_oe, 1'b0);
      chk("rst_mid:irq_n", bus.irq_n, 1'b1);
      chk("rst_mid:stretch", bus.stretch, 1'b0);
      chk("rst_mid:count", bus.cycle_count, 16'h0000);
      rst     = 1'b0;
      m_count = 16'd0;
      m_ticks = 0;
      run_cycle(16'hFD00, 1'b1, 8'h00, 1'b1, 8'h3C, "rdFD00");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
